// File: rtl/pixel_generation_circuit.sv
// Pong object generator: animates ball and paddle once per frame and colours
// each scan pixel from wall/paddle/ball hit tests, with a registered rgb output.
module pixel_generation_circuit (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  btn,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  output logic [11:0] rgb
);

  localparam logic [9:0] H_MAX   = 10'd640;
  localparam logic [9:0] V_MAX   = 10'd480;
  localparam logic [9:0] WALL_L  = 10'd32;
  localparam logic [9:0] WALL_R  = 10'd35;
  localparam logic [9:0] PAD_L   = 10'd600;
  localparam logic [9:0] PAD_R   = 10'd603;
  localparam logic [9:0] PAD_H   = 10'd72;
  localparam logic [9:0] PAD_V   = 10'd4;
  localparam logic [9:0] BALL_SZ = 10'd8;
  localparam logic [9:0] BALL_V  = 10'd2;

  localparam logic [9:0] PAD_Y0  = 10'd204;
  localparam logic [9:0] BALL_X0 = 10'd320;
  localparam logic [9:0] BALL_Y0 = 10'd240;
  localparam logic [9:0] V_POS   = BALL_V;
  localparam logic [9:0] V_NEG   = 10'd0 - BALL_V;

  localparam logic [11:0] COL_BG   = 12'h000;
  localparam logic [11:0] COL_WALL = 12'h00F;
  localparam logic [11:0] COL_PAD  = 12'h0F0;
  localparam logic [11:0] COL_BALL = 12'hF00;

  logic [9:0]  pad_y_q, pad_y_d;
  logic [9:0]  ball_x_q, ball_x_d;
  logic [9:0]  ball_y_q, ball_y_d;
  logic [9:0]  vx_q, vx_d;
  logic [9:0]  vy_q, vy_d;
  logic [11:0] rgb_q, rgb_d;

  logic       refr_tick;
  logic [9:0] pad_bot, ball_r, ball_b;
  logic       wall_on, pad_on, ball_on;

  assign refr_tick = (pixel_y == 10'd481) && (pixel_x == 10'd0);

  // Bottom/right object edges wrap modulo 1024, like the state registers.
  assign pad_bot = pad_y_q + PAD_H - 10'd1;
  assign ball_r  = ball_x_q + BALL_SZ - 10'd1;
  assign ball_b  = ball_y_q + BALL_SZ - 10'd1;

  assign wall_on = (pixel_x >= WALL_L) && (pixel_x <= WALL_R);
  assign pad_on  = (pixel_x >= PAD_L) && (pixel_x <= PAD_R) &&
                   (pixel_y >= pad_y_q) && (pixel_y <= pad_bot);
  assign ball_on = (pixel_x >= ball_x_q) && (pixel_x <= ball_r) &&
                   (pixel_y >= ball_y_q) && (pixel_y <= ball_b);

  always_comb begin
    pad_y_d  = pad_y_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    if (refr_tick) begin
      if (btn == 2'b01 && pad_bot < V_MAX - 10'd5)
        pad_y_d = pad_y_q + PAD_V;
      else if (btn == 2'b10 && pad_y_q > PAD_V)
        pad_y_d = pad_y_q - PAD_V;

      // A ball past the paddle's right edge is a miss and reloads the serve.
      if (ball_x_q >= H_MAX - BALL_SZ) begin
        ball_x_d = BALL_X0;
        ball_y_d = BALL_Y0;
        vx_d     = V_NEG;
        vy_d     = V_POS;
      end else begin
        ball_x_d = ball_x_q + vx_q;
        ball_y_d = ball_y_q + vy_q;
        if (ball_y_q <= 10'd1)
          vy_d = V_POS;
        else if (ball_b >= V_MAX - 10'd2)
          vy_d = V_NEG;
        if (ball_x_q <= WALL_R)
          vx_d = V_POS;
        else if (ball_r >= PAD_L && ball_r <= PAD_R &&
                 ball_b >= pad_y_q && ball_y_q <= pad_bot)
          vx_d = V_NEG;
      end
    end
  end

  always_comb begin
    rgb_d = COL_BG;
    if (!video_on)
      rgb_d = COL_BG;
    else if (wall_on)
      rgb_d = COL_WALL;
    else if (pad_on)
      rgb_d = COL_PAD;
    else if (ball_on)
      rgb_d = COL_BALL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_y_q  <= PAD_Y0;
      ball_x_q <= BALL_X0;
      ball_y_q <= BALL_Y0;
      vx_q     <= V_NEG;
      vy_q     <= V_POS;
      rgb_q    <= COL_BG;
    end else begin
      pad_y_q  <= pad_y_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      rgb_q    <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_pixel_generation_circuit.sv
// Scoreboard bench for pixel_generation_circuit: a frame-level Pong model
// predicts colours; a monitor pops expectations one cycle after each check.
module tb_pixel_generation_circuit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  btn = 2'b00;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        video_on = 1'b0;
  logic [11:0] rgb;

  pixel_generation_circuit dut (
    .clk(clk), .rst(rst), .btn(btn), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic        chk_req = 1'b0;
  logic [11:0] exp_q[$];
  string       name_q[$];
  logic [11:0] mon_e;
  string       mon_n;

  // Game model: plain integers, updated once per frame tick.
  int m_pad, m_bx, m_by, m_vx, m_vy;

  task automatic model_reset();
    m_pad = 204; m_bx = 320; m_by = 240; m_vx = -2; m_vy = 2;
  endtask

  task automatic model_tick(input logic [1:0] b);
    int nvx, nvy, old_pad, bot;
    nvx = m_vx; nvy = m_vy; old_pad = m_pad;
    bot = (m_by + 7) % 1024;
    if (b == 2'b01 && m_pad + 71 < 475) m_pad = m_pad + 4;
    else if (b == 2'b10 && m_pad > 4) m_pad = m_pad - 4;
    if (m_bx >= 632) begin
      m_bx = 320; m_by = 240; m_vx = -2; m_vy = 2;
    end else begin
      if (m_by <= 1) nvy = 2;
      else if (bot >= 478) nvy = -2;
      if (m_bx <= 35) nvx = 2;
      else if (m_bx + 7 >= 600 && m_bx + 7 <= 603 && bot >= old_pad && m_by <= old_pad + 71)
        nvx = -2;
      m_bx = (m_bx + m_vx + 1024) % 1024;
      m_by = (m_by + m_vy + 1024) % 1024;
      m_vx = nvx; m_vy = nvy;
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int x, input int y, input bit von);
    if (!von) return 12'h000;
    if (x >= 32 && x <= 35) return 12'h00F;
    if (x >= 600 && x <= 603 && y >= m_pad && y <= m_pad + 71) return 12'h0F0;
    if (x >= m_bx && x <= m_bx + 7 && y >= m_by && y <= m_by + 7) return 12'hF00;
    return 12'h000;
  endfunction

  task automatic apply(input int x, input int y, input bit von, input logic [1:0] b,
                       input bit r, input bit chk, input string nm);
    @(negedge clk);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von; btn = b; rst = r;
    if (chk) begin
      exp_q.push_back(r ? 12'h000 : exp_rgb(x, y, von));
      name_q.push_back(nm);
    end
    chk_req = chk;
    if (r) model_reset();
    else if (x == 0 && y == 481) model_tick(b);
  endtask

  task automatic pix(input int x, input int y, input string nm);
    apply(x, y, 1'b1, 2'b00, 1'b0, 1'b1, nm);
  endtask

  task automatic tick(input logic [1:0] b);
    apply(0, 481, 1'b0, b, 1'b0, 1'b0, "tick");
  endtask

  task automatic check_ball(input string nm);
    int bx, by;
    bx = m_bx; by = m_by;
    pix(bx, by, {nm, "_tl"});
    pix(bx + 7, by + 7, {nm, "_br"});
    pix(bx + 8, by, {nm, "_right_out"});
    pix(bx + 3, by + 8, {nm, "_below_out"});
    if (bx > 0) pix(bx - 1, by + 3, {nm, "_left_out"});
  endtask

  always @(posedge clk) begin
    if (chk_req) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: rgb=%h with no expectation", rgb);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if (rgb !== mon_e) begin
          errors++;
          $display("FAIL %s: rgb=%h expected=%h", mon_n, rgb, mon_e);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int rx, ry;
    bit done;
    model_reset();
    apply(256, 128, 1'b1, 2'b00, 1'b1, 1'b0, "rst0");
    apply(601, 210, 1'b1, 2'b00, 1'b1, 1'b1, "reset_rgb");

    apply(256, 128, 1'b0, 2'b00, 1'b0, 1'b1, "blank_bg");
    pix(256, 128, "visible_bg");
    pix(33, 100, "wall");
    pix(601, 210, "paddle");
    pix(323, 243, "ball");

    tick(2'b00);
    pix(318, 242, "ball_moved");
    pix(326, 242, "ball_moved_right_out");

    for (int i = 0; i < 51; i++) tick(2'b10);
    pix(601, 4, "pad_top_in");
    pix(601, 3, "pad_top_out");
    pix(601, 75, "pad_bot_in");
    pix(601, 76, "pad_bot_out");
    for (int i = 0; i < 3; i++) tick(2'b11);
    pix(601, 4, "pad_hold_in");
    pix(601, 3, "pad_hold_out");
    check_ball("after_pad");

    guard = 0;
    while (m_bx > 35 && guard < 400) begin tick(2'b00); guard++; end
    check_ball("wall_hit");
    for (int i = 0; i < 3; i++) tick(2'b00);
    check_ball("wall_bounced");

    guard = 0; done = 0;
    while (!done && guard < 600) begin
      done = (m_by + 7) % 1024 >= 478;
      tick(2'b00); guard++;
    end
    for (int i = 0; i < 2; i++) tick(2'b00);
    check_ball("bottom_bounce");

    guard = 0; done = 0;
    while (!done && guard < 600) begin
      done = m_by <= 1;
      tick(2'b00); guard++;
    end
    for (int i = 0; i < 2; i++) tick(2'b00);
    check_ball("top_bounce");

    guard = 0;
    while (m_bx < 632 && guard < 4000) begin
      tick(2'b10); guard++;
      if (guard % 97 == 0) check_ball("travel");
    end
    checks++;
    if (m_bx < 632) begin
      errors++;
      $display("FAIL miss_reach: ball_x=%0d required>=632 within budget", m_bx);
    end
    check_ball("pre_miss");
    tick(2'b00);
    check_ball("miss_reload");

    for (int i = 0; i < 37; i++) tick(2'b01);
    apply(320, 240, 1'b1, 2'b00, 1'b1, 1'b1, "mid_reset_rgb");
    pix(601, 204, "post_reset_pad");
    pix(601, 203, "post_reset_pad_out");
    check_ball("post_reset");

    for (int i = 0; i < 1500; i++) begin
      tick(2'($urandom_range(0, 3)));
      case ($urandom_range(0, 3))
        0: begin rx = $urandom_range(0, 639); ry = $urandom_range(0, 524); end
        1: begin rx = m_bx - 2 + $urandom_range(0, 11); ry = m_by - 2 + $urandom_range(0, 11); end
        2: begin rx = $urandom_range(598, 605); ry = m_pad - 2 + $urandom_range(0, 75); end
        default: begin rx = $urandom_range(30, 37); ry = $urandom_range(0, 479); end
      endcase
      if (rx < 0) rx = 0;
      if (ry < 0) ry = 0;
      if (ry > 1000) ry = 0;
      apply(rx, ry, 1'($urandom_range(0, 7) != 0), 2'b00, 1'b0, 1'b1, "random_pixel");
      if (i % 50 == 0) check_ball("random_ball");
    end

    @(negedge clk);
    chk_req = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin @(negedge clk); guard++; end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_generation_circuit.md
# pixel_generation_circuit

Object-mapped graphics generator for the single-player Pong game. It sits between the VGA sync controller and the RGB output pins. Per frame it animates a ball and a button-controlled paddle, then colours each pixel from the current scan coordinates. The sync controller supplies `pixel_x`, `pixel_y` and `video_on`; this block returns a 12-bit colour.

## Interface
Parameters are fixed constants, not overridable:
- `H_MAX` = 640: visible width.
- `V_MAX` = 480: visible height.
- `WALL_L`, `WALL_R` = 32, 35: left wall x-span.
- `PAD_L`, `PAD_R` = 600, 603: paddle x-span.
- `PAD_H` = 72: paddle height.
- `PAD_V` = 4: paddle step per frame.
- `BALL_SZ` = 8: ball square size.
- `BALL_V` = 2: ball speed per axis per frame.

Ports:
- `clk` in 1: system clock. One clock domain; synchronous, active-high reset.
- `rst` in 1: synchronous active-high reset.
- `btn` in 2: `btn[1]` = paddle up, `btn[0]` = paddle down.
- `pixel_x` in 10: current scan column.
- `pixel_y` in 10: current scan row.
- `video_on` in 1: high inside the visible area.
- `rgb` out 12: {R[3:0],G[3:0],B[3:0]}, registered.

## Operation
- `refr_tick` = (`pixel_y`==481 && `pixel_x`==0). It is combinational and occurs once per frame. All object state changes only on a clock edge where `refr_tick`=1.
- State registers (10-bit unsigned unless noted):
  - `pad_y`: paddle top.
  - `ball_x`, `ball_y`: ball top-left.
  - `vx`, `vy`: 10-bit two's complement, value ±2.
- Reset values: `pad_y`=204, `ball_x`=320, `ball_y`=240, `vx`=-2, `vy`=+2, `rgb`=12'h000.
- Paddle, on tick:
  - `btn`=01 and `pad_y`+71 < 475: `pad_y` += 4.
  - `btn`=10 and `pad_y` > 4: `pad_y` -= 4.
  - `btn`=00 or 11: hold.
- Ball position, on tick: `ball_x` += `vx`, `ball_y` += `vy`. Addition is modulo 1024 and uses the pre-update velocity.
- Ball velocity, on tick, from pre-update position:
  - `ball_y` ≤ 1: `vy`=+2.
  - `ball_y`+7 ≥ 478: `vy`=-2.
  - `ball_x` ≤ 35: `vx`=+2.
  - `ball_x`+7 in [600,603] and `ball_y`+7 ≥ `pad_y` and `ball_y` ≤ `pad_y`+71: `vx`=-2.
  - Otherwise unchanged.
- Miss: on tick with `ball_x` ≥ 632, the ball reloads the reset position and velocity instead of moving. Miss overrides all bounce rules.
- Object hits, combinational on the current `pixel_x`/`pixel_y`, all ranges inclusive:
  - wall: x in [32,35].
  - paddle: x in [600,603] and y in [`pad_y`, `pad_y`+71].
  - ball: x in [`ball_x`, `ball_x`+7] and y in [`ball_y`, `ball_y`+7].
- Colour selection, highest priority first:
  - `video_on`=0: 12'h000.
  - wall: 12'h00F.
  - paddle: 12'h0F0.
  - ball: 12'hF00.
  - otherwise background 12'h000.

## Timing
- `rgb` is registered with 1-clock latency from `pixel_x`/`pixel_y`/`video_on`. Hit tests use the object state present before that edge.
- Object state updates at most once per frame, on the `refr_tick` edge. Holding `refr_tick` for N cycles produces N updates; the sync controller normally guarantees one.
- A `btn` change takes effect at the next tick only; buttons are not latched between ticks.
- Reset has priority over `refr_tick`. Reset mid-frame restores all state on that edge and forces `rgb`=0 on the following cycle.
- Bounce and position update happen on the same edge. The new velocity applies from the next tick, so the ball may overshoot a boundary by up to 2 pixels for one frame.

## Test plan
- Reset, then `rst`=0, `video_on`=0, pixel (256,128) -> `rgb`=12'h000. Repeat with `video_on`=1 -> still 12'h000 (background).
- After reset, `video_on`=1, sample three pixels -> `rgb`=12'h00F, 12'h0F0, 12'hF00 respectively, each one cycle after the pixel is applied:
  - (33,100) -> wall.
  - (601,210) -> paddle.
  - (323,243) -> ball.
- One tick (`pixel_y`=481, `pixel_x`=0, one cycle), `btn`=00 -> ball at (318,242). Check via pixel (318,242) -> 12'hF00 and pixel (326,242) -> 12'h000.
- `btn`=10 held for 51 ticks -> `pad_y` stops at 4: pixel (601,4) red/green check = 12'h0F0, pixel (601,3) = 12'h000. `btn`=11 -> no movement.
- Ball driven by ticks until `ball_x` ≤ 35 -> `vx` becomes +2 and `ball_x` increases on subsequent ticks. Top/bottom bounce checked likewise at `ball_y` ≤ 1 and `ball_y`+7 ≥ 478.
- Paddle moved away, ball allowed past the paddle to `ball_x` ≥ 632 -> next tick reloads (320,240). Assert `rst` mid-animation -> all state returns to reset values on that edge.
